ysyx_25020037_ifu: RTL and testbench

YSYX_25020037_IFU -- requirements
Module: ysyx_25020037_ifu

---
 rtl/ysyx_25020037_ifu.sv | 123 ++++++++++++
 tb/tb_ysyx_25020037_ifu.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: one outstanding I-cache request at a time, a single
// instruction register toward decode, and redirect handling that squashes stale fetches.
module ysyx_25020037_ifu #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_req,
  input  logic [DATA_WIDTH-1:0] ic_data,
  input  logic                  ic_ready,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0] pc_o_q, pc_o_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  kill_q, kill_d;
  logic                  ic_req_q, ic_req_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] redir_tgt;
  logic                  redir_lsb_unused;

  assign redir_tgt        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign redir_lsb_unused = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    pc_o_d     = pc_o_q;
    inst_d     = inst_q;
    kill_d     = kill_q;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) pc_d = redir_tgt;
        state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
        if (redirect_valid) begin
          pc_d   = redir_tgt;
          kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) pc_d = redir_tgt;
        if (ic_ready) begin
          // A killed or simultaneously redirected response is dropped and refetched.
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            state_d = S_VALID;
            inst_d  = ic_data;
            pc_o_d  = req_addr_q;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_VALID: begin
        if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_o_q + ADDR_WIDTH'(4);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Latch the fetch address on entry to REQ so ic_addr is valid alongside ic_req.
    if (state_d == S_REQ) req_addr_d = pc_d;
    ic_req_d    = (state_d == S_REQ);
    out_valid_d = (state_d == S_VALID);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      pc_o_q      <= '0;
      inst_q      <= '0;
      kill_q      <= 1'b0;
      ic_req_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      pc_o_q      <= pc_o_d;
      inst_q      <= inst_d;
      kill_q      <= kill_d;
      ic_req_q    <= ic_req_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ic_addr   = req_addr_q;
  assign ic_req    = ic_req_q;
  assign inst_o    = inst_q;
  assign pc_o      = pc_o_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Bench for ysyx_25020037_ifu: cache responder with variable latency, random decode
// back-pressure and redirects, checked against a program-order fetch model.
module tb_ysyx_25020037_ifu;
  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ic_addr;
  logic          ic_req;
  logic [DW-1:0] ic_data;
  logic          ic_ready;
  logic [DW-1:0] inst_o;
  logic [AW-1:0] pc_o;
  logic          out_valid;
  logic          out_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;

  ysyx_25020037_ifu #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ic_addr       (ic_addr),
    .ic_req        (ic_req),
    .ic_data       (ic_data),
    .ic_ready      (ic_ready),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Reference model state: program-order next pc plus a single-entry cache.
  logic [31:0] exp_pc;
  bit          pend;
  int          cnt;
  logic [31:0] pend_addr;
  bit          killed;
  bit          prev_live, prev_hold, prev_redir;
  logic [31:0] prev_pc, prev_inst;
  int          cyc;
  logic [31:0] req_q[$];
  int          req_cyc[$];
  logic [31:0] dlv_q[$];
  int          dlv_cyc[$];

  // Stimulus knobs.
  int          lat_lo, lat_hi, rdy_pct, redir_pct, redir_mode;
  logic [31:0] redir_tgt;

  function automatic logic [31:0] req_at(int i);
    return (i < req_q.size()) ? req_q[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic logic [31:0] dlv_at(int i);
    return (i < dlv_q.size()) ? dlv_q[i] : 32'hxxxx_xxxx;
  endfunction
  function automatic int req_cyc_at(int i);
    return (i < req_cyc.size()) ? req_cyc[i] : -1000;
  endfunction
  function automatic int dlv_cyc_at(int i);
    return (i < dlv_cyc.size()) ? dlv_cyc[i] : -1000;
  endfunction

  task automatic set_knobs(int lo, int hi, int rdy, int rp);
    lat_lo = lo; lat_hi = hi; rdy_pct = rdy; redir_pct = rp; redir_mode = 0;
  endtask

  task automatic reset_model();
    exp_pc = RESET_PC; pend = 0; cnt = 0; pend_addr = '0; killed = 0;
    prev_live = 0; prev_hold = 0; prev_redir = 0; prev_pc = '0; prev_inst = '0;
    cyc = 0;
    req_q.delete(); req_cyc.delete(); dlv_q.delete(); dlv_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ic_ready = 1'b0; ic_data = '0; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ic_req", ic_req, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_pc_o", pc_o, 32'h0);
    check_eq("rst_inst_o", inst_o, 32'h0);
    check_eq("rst_ic_addr", ic_addr, RESET_PC);
    rst = 1'b0;
    reset_model();
  endtask

  // One clock: drive inputs after the falling edge, check outputs, advance the model.
  task automatic step();
    bit live_n;
    @(negedge clk);
    cyc++;
    ic_ready = 1'b0;
    ic_data  = '0;
    if (pend) begin
      check_eq("ic_addr_hold", ic_addr, pend_addr);
      cnt--;
      if (cnt == 0) begin
        ic_ready = 1'b1;
        ic_data  = mem_word(pend_addr);
      end
    end
    out_ready      = ($urandom_range(99) < rdy_pct);
    redirect_valid = (redir_pct > 0) && ($urandom_range(99) < redir_pct);
    redirect_pc    = $urandom;
    if ((redir_mode == 1 && pend && !ic_ready) ||
        (redir_mode == 2 && ic_ready) ||
        (redir_mode == 3 && out_valid && out_ready)) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_mode     = 0;
    end

    if (ic_req) begin
      check_eq("one_outstanding", pend, 1'b0);
      check_eq("req_addr", ic_addr, exp_pc);
      req_q.push_back(ic_addr);
      req_cyc.push_back(cyc);
    end
    if (prev_redir) check_eq("drop_after_redirect", out_valid, 1'b0);
    if (prev_live)  check_eq("valid_after_ready", out_valid, 1'b1);
    if (prev_hold) begin
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_pc", pc_o, prev_pc);
      check_eq("hold_inst", inst_o, prev_inst);
    end
    if (out_valid) check_eq("valid_source", prev_live || prev_hold, 1'b1);
    if (out_valid && out_ready) begin
      check_eq("dlv_pc", pc_o, exp_pc);
      check_eq("dlv_inst", inst_o, mem_word(pc_o));
      dlv_q.push_back(pc_o);
      dlv_cyc.push_back(cyc);
      exp_pc = pc_o + 32'd4;
    end
    if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};

    live_n = ic_ready && !killed && !redirect_valid;
    if (pend && redirect_valid) killed = 1;
    if (ic_ready) begin
      pend = 0;
      killed = 0;
    end
    if (ic_req) begin
      pend      = 1;
      cnt       = $urandom_range(lat_hi, lat_lo);
      pend_addr = ic_addr;
      killed    = redirect_valid;
    end
    prev_live  = live_n;
    prev_redir = redirect_valid;
    prev_hold  = out_valid && !out_ready && !redirect_valid;
    prev_pc    = pc_o;
    prev_inst  = inst_o;
  endtask

  task automatic run_until_dlv(int n, int budget, string tag);
    int k = 0;
    while (dlv_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check_eq({tag, "_done"}, 32'(dlv_q.size() >= n), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    rst = 1'b1; ic_ready = 1'b0; ic_data = '0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; redir_tgt = '0;
    set_knobs(2, 2, 100, 0);
    reset_model();

    // Back-to-back hits with decode always ready.
    set_knobs(2, 2, 100, 0);
    do_reset();
    run_until_dlv(2, 20, "hit");
    check_eq("hit_req0", req_at(0), 32'h8000_0000);
    check_eq("hit_dlv0", dlv_at(0), 32'h8000_0000);
    check_eq("hit_dlv1", dlv_at(1), 32'h8000_0004);
    check_eq("hit_req_lat", 32'(dlv_cyc_at(0) - req_cyc_at(0)), 32'd3);
    check_eq("hit_spacing", 32'(dlv_cyc_at(1) - dlv_cyc_at(0)), 32'd4);
    check_eq("hit_req_spacing", 32'(req_cyc_at(1) - req_cyc_at(0)), 32'd4);

    // Slow cache: response six cycles after the request.
    set_knobs(6, 6, 100, 0);
    do_reset();
    run_until_dlv(1, 30, "miss");
    check_eq("miss_lat", 32'(dlv_cyc_at(0) - req_cyc_at(0)), 32'd7);
    check_eq("miss_one_req", 32'(req_q.size()), 32'd1);

    // Decode stalls for five cycles while an instruction is held.
    set_knobs(2, 2, 0, 0);
    do_reset();
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check_eq("stall_valid_seen", out_valid, 1'b1);
    n0 = req_q.size();
    repeat (4) step();
    check_eq("stall_no_req", 32'(req_q.size()), 32'(n0));
    rdy_pct = 100;
    step();
    step();
    check_eq("stall_req_after", 32'(req_cyc_at(1)), 32'(dlv_cyc_at(0) + 1));

    // Redirect during WAIT with a misaligned target.
    set_knobs(3, 3, 100, 0);
    redir_mode = 1; redir_tgt = 32'h8000_0103;
    do_reset();
    run_until_dlv(1, 30, "rw");
    check_eq("rw_dlv0", dlv_at(0), 32'h8000_0100);
    check_eq("rw_req1", req_at(1), 32'h8000_0100);

    // Redirect in the same cycle as the cache response.
    set_knobs(2, 2, 100, 0);
    redir_mode = 2; redir_tgt = 32'h8000_2000;
    do_reset();
    run_until_dlv(1, 30, "rr");
    check_eq("rr_dlv0", dlv_at(0), 32'h8000_2000);
    check_eq("rr_req1", req_at(1), 32'h8000_2000);

    // Redirect in the same cycle as the decode handshake.
    set_knobs(2, 2, 100, 0);
    redir_mode = 3; redir_tgt = 32'h8000_3000;
    do_reset();
    run_until_dlv(2, 30, "rh");
    check_eq("rh_dlv0", dlv_at(0), 32'h8000_0000);
    check_eq("rh_dlv1", dlv_at(1), 32'h8000_3000);
    check_eq("rh_req1", req_at(1), 32'h8000_3000);

    // Sequential fetch wraps past the top of the address space.
    set_knobs(2, 2, 100, 0);
    redir_mode = 1; redir_tgt = 32'hFFFF_FFFC;
    do_reset();
    run_until_dlv(2, 40, "wrap");
    check_eq("wrap_dlv0", dlv_at(0), 32'hFFFF_FFFC);
    check_eq("wrap_dlv1", dlv_at(1), 32'h0000_0000);
    check_eq("wrap_req2", req_at(2), 32'h0000_0000);

    // Asynchronous reset in the middle of a fetch, late response while idle.
    set_knobs(5, 5, 100, 0);
    do_reset();
    run_until_dlv(1, 30, "ar");
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("ar_ic_addr", ic_addr, RESET_PC);
    check_eq("ar_out_valid", out_valid, 1'b0);
    check_eq("ar_ic_req", ic_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ic_ready = 1'b1;
    ic_data = 32'hdead_beef;
    reset_model();
    set_knobs(2, 2, 100, 0);
    run_until_dlv(1, 20, "ar_after");
    check_eq("ar_req0", req_at(0), RESET_PC);
    check_eq("ar_dlv0", dlv_at(0), RESET_PC);

    // Random latency, back-pressure and redirects.
    set_knobs(1, 6, 70, 6);
    do_reset();
    repeat (3000) step();
    check_eq("rand_progress", 32'(dlv_q.size() > 50), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
